// File: rtl/fft_axi_pkg.sv
// Shared types and constants for the FFT accelerator AXI burst initiator.
package fft_axi_pkg;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned LEN_W    = 8;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_2B    = 3'b001;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_STRB_2B    = 2'b11;

  localparam int unsigned DEFAULT_WR_ID = 0;
  localparam int unsigned DEFAULT_RD_ID = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_AR,
    S_R,
    S_DONE
  } state_t;

endpackage

// File: rtl/axi_beat_counter.sv
// Beat counter shared by the write-data and read-data phases.
module axi_beat_counter
  import fft_axi_pkg::*;
(
  input  logic             clk,
  input  logic             Reset,
  input  logic             clr,
  input  logic             en,
  input  logic [LEN_W-1:0] len,
  output logic             at_last
);

  logic [LEN_W-1:0] count;

  // Count accepted beats; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (Reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + LEN_W'(1);
    end
  end

  assign at_last = (count == len);

endmodule

// File: rtl/fft_axi_master.sv
// Single-command AXI initiator: write one sample burst, then read one result burst.
module fft_axi_master
  import fft_axi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_W_WIDTH = 2,
  parameter int unsigned ID_R_WIDTH = 2,
  parameter int unsigned WR_ID      = DEFAULT_WR_ID,
  parameter int unsigned RD_ID      = DEFAULT_RD_ID
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [LEN_W-1:0]      len,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [ADDR_W-1:0]     rd_addr,
  input  logic [SAMPLE_W-1:0]   s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic                  r_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic [LEN_W-1:0]      AWLEN,
  output logic [2:0]            AWSIZE,
  output logic [1:0]            AWBURST,
  output logic [ID_W_WIDTH-1:0] AWID,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [SAMPLE_W-1:0]   WDATA,
  output logic [1:0]            WSTRB,
  output logic                  WVALID,
  output logic                  WLAST,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic [ID_W_WIDTH-1:0] BID,
  output logic                  BREADY,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic [LEN_W-1:0]      ARLEN,
  output logic [2:0]            ARSIZE,
  output logic [1:0]            ARBURST,
  output logic [ID_R_WIDTH-1:0] ARID,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [ID_R_WIDTH-1:0] RID,
  input  logic                  RVALID,
  input  logic                  RLAST,
  output logic                  RREADY
);

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic             in_w;
  logic             in_r;
  logic             w_hs;
  logic             r_hs;
  logic             at_last;
  logic             cnt_clr;

  assign in_w = (state == S_W);
  assign in_r = (state == S_R);
  assign w_hs = in_w && s_valid && WREADY;
  assign r_hs = in_r && RVALID && r_ready;

  // Counter is parked at zero while idle and rewound before the read burst.
  assign cnt_clr = (state == S_IDLE) || (state == S_AR);

  axi_beat_counter u_beat_counter (
    .clk     (clk),
    .Reset   (Reset),
    .clr     (cnt_clr),
    .en      (w_hs || r_hs),
    .len     (len_q),
    .at_last (at_last)
  );

  // Write-data and read-data channels pass straight through during their phase.
  assign WVALID  = in_w && s_valid;
  assign WDATA   = s_data;
  assign WLAST   = in_w && at_last;
  assign s_ready = in_w && WREADY;
  assign r_valid = in_r && RVALID;
  assign r_data  = RDATA;
  assign r_last  = in_r && at_last;
  assign RREADY  = in_r && r_ready;

  assign AWLEN   = len_q;
  assign ARLEN   = len_q;
  assign AWSIZE  = AXI_SIZE_2B;
  assign ARSIZE  = AXI_SIZE_4B;
  assign AWBURST = AXI_BURST_INCR;
  assign ARBURST = AXI_BURST_INCR;
  assign WSTRB   = AXI_STRB_2B;

  // Command sequencer with registered address-channel, response and status outputs.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state   <= S_IDLE;
      len_q   <= '0;
      AWADDR  <= '0;
      ARADDR  <= '0;
      AWID    <= '0;
      ARID    <= '0;
      AWVALID <= 1'b0;
      ARVALID <= 1'b0;
      BREADY  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_AW;
            len_q   <= len;
            AWADDR  <= wr_addr;
            ARADDR  <= rd_addr;
            AWID    <= ID_W_WIDTH'(WR_ID);
            ARID    <= ID_R_WIDTH'(RD_ID);
            AWVALID <= 1'b1;
            busy    <= 1'b1;
            err     <= 1'b0;
          end
        end
        S_AW: begin
          if (AWREADY) begin
            AWVALID <= 1'b0;
            state   <= S_W;
          end
        end
        S_W: begin
          if (w_hs && at_last) begin
            BREADY <= 1'b1;
            state  <= S_B;
          end
        end
        S_B: begin
          if (BVALID) begin
            BREADY  <= 1'b0;
            ARVALID <= 1'b1;
            state   <= S_AR;
            if (BID != ID_W_WIDTH'(WR_ID)) begin
              err <= 1'b1;
            end
          end
        end
        S_AR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            state   <= S_R;
          end
        end
        S_R: begin
          if (r_hs) begin
            // Wrong ID, missing RLAST on the final beat, or early RLAST all flag an error.
            if ((RID != ID_R_WIDTH'(RD_ID)) || (RLAST != at_last)) begin
              err <= 1'b1;
            end
            if (RLAST || at_last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_axi_master.sv
// Directed bench for fft_axi_master with a small AXI slave model and result scoreboard.
module tb_fft_axi_master;

  logic        clk = 1'b0;
  logic        Reset;
  logic        start;
  logic [7:0]  len;
  logic [11:0] wr_addr, rd_addr;
  logic [15:0] s_data;
  logic        s_valid, s_ready;
  logic [31:0] r_data;
  logic        r_valid, r_ready, r_last;
  logic        busy, done, err;
  logic [11:0] AWADDR, ARADDR;
  logic [7:0]  AWLEN, ARLEN;
  logic [2:0]  AWSIZE, ARSIZE;
  logic [1:0]  AWBURST, ARBURST, AWID, ARID, BID, RID, WSTRB;
  logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
  logic [15:0] WDATA;
  logic [31:0] RDATA;

  fft_axi_master dut (
    .clk(clk), .Reset(Reset), .start(start), .len(len), .wr_addr(wr_addr), .rd_addr(rd_addr),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .busy(busy), .done(done), .err(err),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
    .BVALID(BVALID), .BID(BID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RID(RID), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Slave / source / sink configuration.
  int cfg_aw_delay = 0;
  int cfg_rlast_at = -1;
  logic [1:0] cfg_bid = 2'b00;
  bit cfg_rand = 1'b0;

  // Current command and scoreboards.
  int cur_len = 0;
  logic [11:0] cur_wr = '0, cur_rd = '0;
  logic [15:0] src_q[$];
  logic [15:0] w_exp[$];
  logic [31:0] r_exp[$];
  logic [15:0] wmem[256];

  // Monitor state.
  int wcnt = 0, rcnt_o = 0, aw_hs_cnt = 0, aw_wait = 0;
  bit aw_hold = 1'b0;
  bit w_hs_f = 1'b0, wlast_f = 1'b0, b_hs_f = 1'b0, ar_hs_f = 1'b0, r_hs_f = 1'b0;

  // Slave internal state.
  int aw_cnt = 0, rcnt = 0;
  bit r_pend = 1'b0, r_act = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {8'h00, s_ready, r_valid, r_last, busy, done, err, AWVALID, WVALID, WLAST,
            BREADY, ARVALID, RREADY, AWADDR, AWLEN, ARADDR, ARLEN, AWID, ARID};
  endfunction

  // Monitor: sample at negedge, record handshakes that the next rising edge will complete.
  always @(negedge clk) begin
    logic [15:0] we;
    logic [31:0] re;
    if (Reset) begin
      w_hs_f = 1'b0; wlast_f = 1'b0; b_hs_f = 1'b0; ar_hs_f = 1'b0; r_hs_f = 1'b0;
      aw_hold = 1'b0;
    end else begin
      w_hs_f  = WVALID && WREADY;
      wlast_f = WLAST;
      b_hs_f  = BVALID && BREADY;
      ar_hs_f = ARVALID && ARREADY;
      r_hs_f  = RVALID && RREADY;
      if (aw_hold) chk("aw_stable", 64'({AWVALID, AWADDR}), 64'({1'b1, cur_wr}));
      aw_hold = AWVALID && !AWREADY;
      if (aw_hold) aw_wait++;
      if (AWVALID && AWREADY) begin
        chk("aw_addr_len", 64'({AWADDR, AWLEN}), 64'({cur_wr, 8'(cur_len)}));
        chk("aw_size_burst_id", 64'({AWSIZE, AWBURST, AWID}), 64'({3'b001, 2'b01, 2'b00}));
        aw_hs_cnt++;
      end
      if (w_hs_f) begin
        if (w_exp.size() > 0) we = w_exp.pop_front(); else we = 'x;
        chk("w_data", 64'(WDATA), 64'(we));
        chk("w_last_strb", 64'({WLAST, WSTRB, s_ready}), 64'({wcnt == cur_len, 2'b11, 1'b1}));
        if (wcnt < 256) wmem[wcnt] = WDATA;
        wcnt++;
      end
      if (ar_hs_f) begin
        chk("ar_addr_len", 64'({ARADDR, ARLEN}), 64'({cur_rd, 8'(cur_len)}));
        chk("ar_size_burst_id", 64'({ARSIZE, ARBURST, ARID}), 64'({3'b010, 2'b01, 2'b00}));
      end
      if (r_valid && r_ready) begin
        if (r_exp.size() > 0) re = r_exp.pop_front(); else re = 'x;
        chk("r_data", 64'(r_data), 64'(re));
        chk("r_last", 64'(r_last), 64'(rcnt_o == cur_len));
        rcnt_o++;
      end
    end
  end

  // Slave, sample source and result sink: update drives just after the rising edge.
  always @(posedge clk) begin
    int rlast_eff;
    #1;
    if (Reset) begin
      AWREADY = 1'b0; BVALID = 1'b0; BID = '0; ARREADY = 1'b0;
      RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
      aw_cnt = 0; rcnt = 0; r_pend = 1'b0; r_act = 1'b0;
      s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
    end else begin
      if (AWVALID) begin
        AWREADY = (aw_cnt >= cfg_aw_delay);
        aw_cnt++;
      end else begin
        AWREADY = 1'b0;
        aw_cnt = 0;
      end
      if (w_hs_f && wlast_f) begin
        BVALID = 1'b1;
        BID = cfg_bid;
      end else if (b_hs_f) begin
        BVALID = 1'b0;
      end
      ARREADY = ARVALID;
      if (r_hs_f) begin
        if (RLAST || rcnt >= cur_len) r_act = 1'b0;
        rcnt++;
      end
      if (ar_hs_f) begin
        rcnt = 0;
        r_pend = 1'b1;
      end else if (r_pend) begin
        r_pend = 1'b0;
        r_act = 1'b1;
      end
      rlast_eff = (cfg_rlast_at < 0) ? cur_len : cfg_rlast_at;
      RVALID = r_act;
      RDATA  = {wmem[rcnt[7:0]], ~wmem[rcnt[7:0]]};
      RLAST  = r_act && (rcnt == rlast_eff);
      if (w_hs_f && src_q.size() > 0) src_q.delete(0);
      if (!(s_valid && !w_hs_f))
        s_valid = (src_q.size() > 0) && (!cfg_rand || $urandom_range(0, 1) == 1);
      s_data  = (src_q.size() > 0) ? src_q[0] : 16'h0000;
      r_ready = !cfg_rand || ($urandom_range(0, 1) == 1);
    end
  end

  task automatic load_burst(input int l, input logic [11:0] wa, input logic [11:0] ra,
                            input logic [15:0] base);
    logic [15:0] s;
    cur_len = l; cur_wr = wa; cur_rd = ra;
    src_q.delete(); w_exp.delete(); r_exp.delete();
    wcnt = 0; rcnt_o = 0; aw_hs_cnt = 0; aw_wait = 0;
    for (int i = 0; i <= l; i++) begin
      s = base + 16'(i);
      src_q.push_back(s);
      w_exp.push_back(s);
      r_exp.push_back({s, ~s});
    end
  endtask

  task automatic pulse_start(input int l, input logic [11:0] wa, input logic [11:0] ra);
    @(posedge clk); #1;
    len = 8'(l); wr_addr = wa; rd_addr = ra; start = 1'b1;
  endtask

  task automatic run_cmd(input int l, input logic [11:0] wa, input logic [11:0] ra,
                         input logic [15:0] base, input int lat_exp, input logic exp_err,
                         input int exp_rbeats);
    int cyc;
    load_burst(l, wa, ra, base);
    pulse_start(l, wa, ra);
    @(negedge clk);
    cyc = 0;
    do begin
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk);
      cyc++;
      if (cyc == 1) chk("start_to_aw", 64'({err, busy, AWVALID}), 64'(3'b011));
    end while (!done && cyc < 4000);
    chk("done_seen", 64'(done), 64'(1));
    if (lat_exp > 0) chk("done_latency", 64'(cyc), 64'(lat_exp));
    chk("err_at_done", 64'(err), 64'(exp_err));
    chk("w_beats", 64'(wcnt), 64'(l + 1));
    chk("r_beats", 64'(rcnt_o), 64'(exp_rbeats));
    chk("aw_handshakes", 64'(aw_hs_cnt), 64'(1));
    @(negedge clk);
    chk("done_pulse_idle", 64'({done, busy}), 64'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    Reset = 1'b1; start = 1'b0; len = '0; wr_addr = '0; rd_addr = '0;
    WREADY = 1'b1; RID = '0;
    s_valid = 1'b0; s_data = '0; r_ready = 1'b0;
    AWREADY = 1'b0; BVALID = 1'b0; BID = '0; ARREADY = 1'b0;
    RVALID = 1'b0; RLAST = 1'b0; RDATA = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", out_vec(), 64'(0));
    @(posedge clk); #2 Reset = 1'b0;
    repeat (2) @(negedge clk);

    // Basic len=3 with all readies high.
    run_cmd(3, 12'h100, 12'h200, 16'h0001, 13, 1'b0, 4);

    // Minimum-latency single beat.
    run_cmd(0, 12'h010, 12'h020, 16'h55AA, 7, 1'b0, 1);

    // AWREADY held low for 5 cycles.
    cfg_aw_delay = 5;
    run_cmd(1, 12'h3C0, 12'h3E0, 16'h1234, 0, 1'b0, 2);
    chk("aw_wait_cycles", 64'(aw_wait), 64'(5));
    cfg_aw_delay = 0;

    // Full 256-beat bursts with random source and sink gaps.
    cfg_rand = 1'b1;
    run_cmd(255, 12'h000, 12'h800, 16'hA000, 0, 1'b0, 256);
    cfg_rand = 1'b0;

    // Wrong BID: error sticky until next start.
    cfg_bid = 2'b01;
    run_cmd(0, 12'h040, 12'h080, 16'h0BAD, 7, 1'b1, 1);
    cfg_bid = 2'b00;
    repeat (3) @(negedge clk);
    chk("err_sticky_idle", 64'(err), 64'(1));
    run_cmd(0, 12'h044, 12'h084, 16'h0600, 7, 1'b0, 1);

    // Early RLAST on beat 2 of 4.
    cfg_rlast_at = 1;
    run_cmd(3, 12'h500, 12'h600, 16'h7000, 0, 1'b1, 2);
    cfg_rlast_at = -1;

    // Reset during the second write beat.
    load_burst(3, 12'h700, 12'h710, 16'h0C00);
    pulse_start(3, 12'h700, 12'h710);
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    do begin
      @(posedge clk); #2;
      cyc++;
    end while (wcnt < 1 && cyc < 100);
    chk("reset_at_beat2", 64'(wcnt), 64'(1));
    Reset = 1'b1;
    @(posedge clk); #2 Reset = 1'b0;
    src_q.delete();
    @(negedge clk);
    chk("reset_mid_burst", out_vec(), 64'(0));
    run_cmd(2, 12'h720, 12'h730, 16'h0D00, 11, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
